// File: rtl/cache_ctrl_pkg.sv
// Shared types and address-field helpers for the direct-mapped cache controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, FILL, WRITE} state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam int TAG_W = 3;
  localparam int IDX_W = 5;
  localparam int WRD_W = 2;

  // Index sits directly above the word-in-line bits regardless of address width.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [IDX_W+WRD_W-1:0] low);
    return low[IDX_W+WRD_W-1:WRD_W];
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/valid arrays for the direct-mapped cache: combinational lookup, one registered write port.
// Async clear on rst_n invalidates every line.
module cache_tag_store
  import cache_ctrl_pkg::*;
#(
  parameter int LINES = 32,
  parameter int TW    = TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TW-1:0]    lookup_tag,
  output logic             lookup_hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TW-1:0]    wr_tag
);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < LINES; i++) tag[i] <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      tag[wr_idx]   <= wr_tag;
    end
  end

  assign lookup_hit = valid[lookup_idx] && (tag[lookup_idx] == lookup_tag);

endmodule

// File: rtl/cache_controller.sv
// Hit/miss sequencer for a direct-mapped write-through, no-write-allocate cache.
// Optional CACHE_STATS_EN adds saturating hit/miss/write counters.
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LINES  = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_rd,
  input  logic [1:0]        cpu_wr,
  output logic              cpu_stall,
  output logic              hit,
  output logic              miss,
  output logic              fill,
  output logic              ready,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] mem_block
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wr_cnt
`endif
);

  localparam int TW = ADDR_W - IDX_W - WRD_W;

  state_t            state, state_n;
  logic [TW-1:0]     cpu_tag, miss_tag;
  logic [IDX_W-1:0]  cpu_idx, miss_idx;
  logic [LINE_W-1:0] line_q;
  logic              tag_hit, rd_req, wr_req;

  assign cpu_tag   = cpu_addr[ADDR_W-1 -: TW];
  assign cpu_idx   = addr_idx(cpu_addr[IDX_W+WRD_W-1:0]);
  assign rd_req    = (cpu_rd != SZ_NONE);
  assign wr_req    = (cpu_wr != SZ_NONE);
  assign hit       = tag_hit;
  assign mem_block = line_q;

  cache_tag_store #(.LINES(LINES), .TW(TW)) u_tags (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_idx (cpu_idx),
    .lookup_tag (cpu_tag),
    .lookup_hit (tag_hit),
    .wr_en      (state == FILL),
    .wr_idx     (miss_idx),
    .wr_tag     (miss_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      miss_tag <= '0;
      miss_idx <= '0;
      line_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && rd_req && !wr_req && !tag_hit) begin
        miss_tag <= cpu_tag;
        miss_idx <= cpu_idx;
      end
      if (state == REFILL && mem_ack) line_q <= mem_rdata;
    end
  end

  always_comb begin
    state_n    = state;
    cpu_stall  = 1'b0;
    miss       = 1'b0;
    fill       = 1'b0;
    ready      = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          mem_wr_req = 1'b1;
          cpu_stall  = 1'b1;
          mem_addr   = cpu_addr;
          state_n    = WRITE;
        end else if (rd_req) begin
          if (!tag_hit) begin
            miss       = 1'b1;
            mem_rd_req = 1'b1;
            cpu_stall  = 1'b1;
            mem_addr   = {cpu_addr[ADDR_W-1:WRD_W], {WRD_W{1'b0}}};
            state_n    = REFILL;
          end
        end else begin
          ready = 1'b1;
        end
      end
      REFILL: begin
        mem_rd_req = 1'b1;
        cpu_stall  = 1'b1;
        mem_addr   = {miss_tag, miss_idx, {WRD_W{1'b0}}};
        if (mem_ack) state_n = FILL;
      end
      FILL: begin
        fill    = 1'b1;
        state_n = IDLE;
      end
      WRITE: begin
        mem_wr_req = 1'b1;
        mem_addr   = cpu_addr;
        cpu_stall  = !mem_ack;
        if (mem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Requests must drop the moment reset asserts, even with a CPU access still presented.
    if (!rst_n) begin
      cpu_stall  = 1'b0;
      miss       = 1'b0;
      fill       = 1'b0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      mem_addr   = '0;
      ready      = 1'b1;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wr_cnt   <= '0;
    end else if (state == IDLE) begin
      if (wr_req && wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 32'd1;
      if (!wr_req && rd_req && tag_hit && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      if (!wr_req && rd_req && !tag_hit && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
